uart_rx_frame: RTL and testbench

- Parametrised, oversampling asynchronous serial receiver. Next generation of the team's fixed 12-bit deserializer.
- Adds configurable data width, oversample ratio and parity mode.
- Adds 3-sample majority voting, false-start rejection, stop-bit/framing and parity checks, a valid/ready output handshake, and overrun reporting.
- Sits between the demodulated FSK bit line and the frame/packet layer.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_frame.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling UART frame receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bit-cycle index of the third (deciding) majority sample within a bit.
  function automatic int decision_offset(input int oversample);
    return oversample / 2 + 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Metastability filter: two back-to-back flops, preset to line-idle
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling asynchronous serial receiver with majority voting, parity/framing
// checks, false-start rejection and a valid/ready holding register.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = 12,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int DEC_OFF = decision_offset(OVERSAMPLE);

  localparam logic [CW-1:0] CNT_S0   = CW'(DEC_OFF - 2);
  localparam logic [CW-1:0] CNT_S1   = CW'(DEC_OFF - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(DEC_OFF);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam bit            HAS_PAR  = (PARITY_MODE != PAR_NONE);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity check result: 1 when the received parity bit disagrees with the mode.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY_MODE == PAR_ODD) return ~x;
    else if (PARITY_MODE == PAR_EVEN) return x;
    else return 1'b0;
  endfunction

  logic                 rx_s;
  rx_state_t            state_q;
  rx_state_t            state_nxt;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic                 armed_q;
  logic                 samp_a;
  logic                 samp_b;
  logic                 at_dec;
  logic                 bit_val;
  logic                 data_dec;
  logic                 par_dec;
  logic                 stop_dec;
  logic [DATA_BITS-1:0] asm_p0;
  logic                 fe_p0;
  logic                 pe_p0;
  logic                 vld_p0;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign at_dec  = (cnt_q == CNT_DEC);
  assign bit_val = maj3(samp_a, samp_b, rx_s);
  assign rx_busy = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic and per-bit decision strobes
  always_comb begin
    state_nxt = state_q;
    data_dec  = 1'b0;
    par_dec   = 1'b0;
    stop_dec  = 1'b0;
    case (state_q)
      IDLE:   if (armed_q && !rx_s) state_nxt = START;
      START:  if (at_dec) state_nxt = bit_val ? IDLE : DATA;
      DATA: begin
        if (at_dec) begin
          data_dec = 1'b1;
          if (bit_idx_q == IDX_LAST) state_nxt = HAS_PAR ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_dec) begin
          par_dec   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (at_dec) begin
          stop_dec  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-cycle counter: starts at 1 on the start edge, wraps every bit, parked at 0 in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= (state_nxt == START) ? CW'(1) : '0;
    end else if (state_nxt == IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Data bit index within the frame
  always_ff @(posedge clk) begin
    if (rst || state_q != DATA) bit_idx_q <= '0;
    else if (data_dec)          bit_idx_q <= bit_idx_q + BW'(1);
  end

  // Start arming: a low stop bit blocks new starts until the line has been seen high
  always_ff @(posedge clk) begin
    if (rst)                          armed_q <= 1'b1;
    else if (state_q == IDLE && rx_s) armed_q <= 1'b1;
    else if (stop_dec && !bit_val)    armed_q <= 1'b0;
  end

  // ---- stage p0: majority samples and LSB-first word assembly ----
  // First two votes of each bit; the third is the live rx_s at the decision point
  always_ff @(posedge clk) begin
    if (cnt_q == CNT_S0) samp_a <= rx_s;
    if (cnt_q == CNT_S1) samp_b <= rx_s;
  end

  // Shift each decided data bit in from the top so bit 0 ends up in the LSB
  always_ff @(posedge clk) begin
    if (data_dec) asm_p0 <= {bit_val, asm_p0[DATA_BITS-1:1]};
  end

  // Per-frame error flags and the frame-complete strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_p0  <= 1'b0;
      pe_p0  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= stop_dec;
      if (state_q == START) pe_p0 <= 1'b0;
      else if (par_dec)     pe_p0 <= parity_bad(asm_p0, bit_val);
      if (stop_dec)         fe_p0 <= ~bit_val;
    end
  end

  // ---- stage p1: holding register with valid/ready handshake and overrun pulse ----
  // Load when empty or being drained this cycle; otherwise drop the new frame and flag it
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= vld_p0 && rx_valid && !rx_ready;
      if (vld_p0 && (!rx_valid || rx_ready)) begin
        rx_data       <= asm_p0;
        rx_frame_err  <= fe_p0;
        rx_parity_err <= pe_p0;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench: directed frames into a default receiver (A) and an
// 8-bit odd-parity receiver (B); monitors compare every accepted word.
module tb_uart_rx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rx_a, rx_b, rdy_a, rdy_b;
  logic [11:0] data_a;
  logic [7:0]  data_b;
  logic        valid_a, fe_a, pe_a, ovr_a, busy_a;
  logic        valid_b, fe_b, pe_b, ovr_b, busy_b;

  uart_rx_frame dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(rdy_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a),
    .rx_overrun(ovr_a), .rx_busy(busy_a)
  );

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2)) dut_b (
    .clk(clk), .rst(rst), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(rdy_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b),
    .rx_overrun(ovr_b), .rx_busy(busy_b)
  );

  typedef struct {
    logic [15:0] d;
    logic        fe;
    logic        pe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt_a = 0, valid_cnt_a = 0, ovr_cnt_a = 0;
  int lat, g_b, g_v, o0;

  logic        held_a, held_b;
  logic [11:0] hd_a;
  logic [7:0]  hd_b;
  logic        hfe_a, hpe_a, hfe_b, hpe_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v, input int ncyc);
    if (which) rx_b = v;
    else       rx_a = v;
    idle(ncyc);
  endtask

  task automatic send_frame(input bit which, input logic [15:0] d, input int nbits,
                            input bit has_par, input logic par, input logic stop);
    drive(which, 1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(which, d[i], 16);
    if (has_par) drive(which, par, 16);
    drive(which, stop, 16);
  endtask

  // Activity counters for A, sampled on the inactive edge
  always @(negedge clk) begin
    busy_cnt_a  <= busy_cnt_a + 32'(busy_a);
    valid_cnt_a <= valid_cnt_a + 32'(valid_a);
    ovr_cnt_a   <= ovr_cnt_a + 32'(ovr_a);
  end

  // Monitor A: compare accepted words, and check held words never change
  initial begin
    exp_t e;
    held_a = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_a = 1'b0;
      end else begin
        if (held_a)
          chk("a_hold_stable", 32'({valid_a, fe_a, pe_a, data_a}), 32'({1'b1, hfe_a, hpe_a, hd_a}));
        if (valid_a && rdy_a) begin
          if (q_a.size() == 0) begin
            chk("a_unexpected_word_qsize", 32'(q_a.size()), 32'd1);
          end else begin
            e = q_a.pop_front();
            chk("a_data", 32'(data_a), 32'(e.d));
            chk("a_frame_err", 32'(fe_a), 32'(e.fe));
            chk("a_parity_err", 32'(pe_a), 32'(e.pe));
          end
        end
        held_a = valid_a && !rdy_a;
        hd_a = data_a; hfe_a = fe_a; hpe_a = pe_a;
      end
    end
  end

  // Monitor B: same checks for the parity receiver
  initial begin
    exp_t e;
    held_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_b = 1'b0;
      end else begin
        if (held_b)
          chk("b_hold_stable", 32'({valid_b, fe_b, pe_b, data_b}), 32'({1'b1, hfe_b, hpe_b, hd_b}));
        if (valid_b && rdy_b) begin
          if (q_b.size() == 0) begin
            chk("b_unexpected_word_qsize", 32'(q_b.size()), 32'd1);
          end else begin
            e = q_b.pop_front();
            chk("b_data", 32'(data_b), 32'(e.d));
            chk("b_frame_err", 32'(fe_b), 32'(e.fe));
            chk("b_parity_err", 32'(pe_b), 32'(e.pe));
          end
        end
        held_b = valid_b && !rdy_b;
        hd_b = data_b; hfe_b = fe_b; hpe_b = pe_b;
      end
    end
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    idle(4);
    chk("rst_held_valid_a", 32'(valid_a), 32'd0);
    chk("rst_held_busy_a", 32'(busy_a), 32'd0);
    rst = 1'b0;
    idle(2);
    chk("rst_data_a", 32'(data_a), 32'd0);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_fe_a", 32'(fe_a), 32'd0);
    chk("rst_pe_a", 32'(pe_a), 32'd0);
    chk("rst_ovr_a", 32'(ovr_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_data_b", 32'(data_b), 32'd0);
    chk("rst_valid_b", 32'(valid_b), 32'd0);

    // 0xA5C, good stop: valid seen after the 221st edge counted from the pin change
    q_a.push_back('{16'h0A5C, 1'b0, 1'b0});
    fork
      send_frame(1'b0, 16'h0A5C, 12, 1'b0, 1'b0, 1'b1);
      begin
        lat = 0;
        do begin
          @(posedge clk);
          @(negedge clk);
          lat++;
        end while (!valid_a && lat < 400);
        chk("a5c_latency_edges", 32'(lat), 32'd221);
        @(negedge clk);
        chk("a5c_pulse_width", 32'(valid_a), 32'd0);
      end
    join
    idle(10);

    // 4-cycle low glitch: false start, no word, short busy
    g_b = busy_cnt_a; g_v = valid_cnt_a;
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 60);
    chk("glitch_busy_1_to_10", 32'((busy_cnt_a - g_b) > 0 && (busy_cnt_a - g_b) <= 10), 32'd1);
    chk("glitch_no_valid", 32'(valid_cnt_a - g_v), 32'd0);

    // Odd parity on B: 0x3C has four ones, parity bit 0 is wrong, 1 is right
    q_b.push_back('{16'h003C, 1'b0, 1'b1});
    send_frame(1'b1, 16'h003C, 8, 1'b1, 1'b0, 1'b1);
    q_b.push_back('{16'h003C, 1'b0, 1'b0});
    send_frame(1'b1, 16'h003C, 8, 1'b1, 1'b1, 1'b1);
    idle(20);

    // Low stop bit, line stuck low, then high, then a clean frame
    q_a.push_back('{16'h0456, 1'b1, 1'b0});
    send_frame(1'b0, 16'h0456, 12, 1'b0, 1'b0, 1'b0);
    g_b = busy_cnt_a;
    drive(1'b0, 1'b0, 40);
    chk("stuck_low_no_start", 32'(busy_cnt_a - g_b), 32'd0);
    drive(1'b0, 1'b1, 32);
    q_a.push_back('{16'h0123, 1'b0, 1'b0});
    send_frame(1'b0, 16'h0123, 12, 1'b0, 1'b0, 1'b1);
    idle(20);

    // Overrun: consumer stalled across two back-to-back frames
    rdy_a = 1'b0;
    o0 = ovr_cnt_a;
    q_a.push_back('{16'h0001, 1'b0, 1'b0});
    send_frame(1'b0, 16'h0001, 12, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 16'h0002, 12, 1'b0, 1'b0, 1'b1);
    idle(5);
    chk("overrun_pulses", 32'(ovr_cnt_a - o0), 32'd1);
    chk("overrun_kept_data", 32'(data_a), 32'h001);
    chk("overrun_still_valid", 32'(valid_a), 32'd1);
    rdy_a = 1'b1;
    idle(1);
    chk("accept_drops_valid", 32'(valid_a), 32'd0);
    idle(10);

    // Reset mid-frame with a word held: everything clears, partial frame lost
    rdy_a = 1'b0;
    send_frame(1'b0, 16'h05A5, 12, 1'b0, 1'b0, 1'b1);
    idle(5);
    chk("pre_rst_valid", 32'(valid_a), 32'd1);
    drive(1'b0, 1'b0, 16);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'(i % 2), 16);
    drive(1'b0, 1'b0, 8);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    idle(1);
    chk("midrst_data", 32'(data_a), 32'd0);
    chk("midrst_valid", 32'(valid_a), 32'd0);
    chk("midrst_fe", 32'(fe_a), 32'd0);
    chk("midrst_pe", 32'(pe_a), 32'd0);
    chk("midrst_ovr", 32'(ovr_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    rx_a = 1'b1;
    idle(2);
    rst = 1'b0;
    rdy_a = 1'b1;
    idle(20);
    q_a.push_back('{16'h07FF, 1'b0, 1'b0});
    send_frame(1'b0, 16'h07FF, 12, 1'b0, 1'b0, 1'b1);
    idle(30);

    chk("a_all_words_delivered", 32'(q_a.size()), 32'd0);
    chk("b_all_words_delivered", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
